uart_tx_fifo_feeder: RTL and testbench



---
 rtl/uart_tx_fifo_feeder.sv | 130 +++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding a UART transmitter one byte at a time, paced by the transmitter's busy flag.
// Optional build macro UART_TX_FIFO_OVF_CNT_EN adds ovf_cnt, a saturating count of overflow pulses.
module uart_tx_fifo_feeder #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          sending,
    output logic [1:0]    dbg_state
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]    ovf_cnt
`endif
);

    // Handshake: push is an unconditional write strobe (no backpressure; a push while full is
    // dropped and flagged). tx_start pulses only from IDLE; the next byte waits until tx_busy
    // has been seen high and then low again.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_IDLE = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    state_t        state_q, state_d;
    logic          full_w, empty_w, push_ok, pop;

    always_comb begin
        full_w     = (count_q == CNT_FULL);
        empty_w    = (count_q == '0);
        push_ok    = push && !full_w;
        overflow_d = push && full_w;
        pop        = 1'b0;
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (tx_busy)  state_d = WAIT_IDLE;
            WAIT_IDLE: if (!tx_busy) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            state_q    <= IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= 8'h00;
        end else if (overflow_d && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign sending   = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder: directed sequences, an overflow vector table and random traffic,
// all checked against a byte-queue reference model and a simple transmitter busy responder.
module tb_uart_tx_fifo_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [7:0]    push_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          sending;
  logic [1:0]    dbg_state;
`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  // ---------------- clock / reset block
  always #5 clk = ~clk;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .sending   (sending),
    .dbg_state (dbg_state)
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  // ---------------- scoreboard / reference model state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  int          occ;
  bit          free_m;
  bit          seen_rise;
  logic [7:0]  last_data;
  int          ovf_m;
  int          n_starts;
  int          peak;

  // transmitter responder
  int          rise_wait;
  int          busy_left;
  int          rise_delay;
  int          busy_len;
  bit          force_busy;
  bit          rand_mode;

  typedef struct {
    logic        push;
    logic [7:0]  data;
    logic [AW:0] exp_count;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_busy();
    if (force_busy) begin
      tx_busy = 1'b1;
    end else if (rise_wait > 0) begin
      rise_wait--;
      if (rise_wait == 0) begin
        tx_busy   = 1'b1;
        busy_left = busy_len;
      end
    end else if (tx_busy) begin
      if (busy_left > 0) busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after the rising edge.
  task automatic step(input logic p, input logic [7:0] d);
    logic busy_e;
    int   pre_occ;
    bit   exp_issue;
    bit   acc;
    push      = p;
    push_data = d;
    drive_busy();
    busy_e    = tx_busy;
    pre_occ   = occ;
    exp_issue = (pre_occ > 0) && free_m;
    @(posedge clk);
    #1;
    acc = p && (pre_occ < DEPTH);
    check("tx_start", int'(tx_start), int'(exp_issue));
    if (tx_start) begin
      n_starts++;
      check("start_while_busy", int'(busy_e), 0);
    end
    if (!free_m) begin
      if (busy_e) seen_rise = 1'b1;
      else if (seen_rise) free_m = 1'b1;
    end
    if (exp_issue) begin
      free_m    = 1'b0;
      seen_rise = 1'b0;
      last_data = exp_q.pop_front();
      occ--;
    end
    if (acc) begin
      exp_q.push_back(d);
      occ++;
    end
    if (p && pre_occ == DEPTH && ovf_m < 255) ovf_m++;
    check("count", int'(count), occ);
    check("empty", int'(empty), int'(occ == 0));
    check("full", int'(full), int'(occ == DEPTH));
    check("overflow", int'(overflow), int'(p && pre_occ == DEPTH));
    check("sending", int'(sending), int'(!free_m));
    check("tx_data", int'(tx_data), int'(last_data));
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("ovf_cnt", int'(ovf_cnt), ovf_m);
`endif
    if (int'(count) > peak) peak = int'(count);
    if (tx_start) begin
      if (rand_mode) begin
        rise_delay = $urandom_range(1, 3);
        busy_len   = $urandom_range(1, 6);
      end
      rise_wait = rise_delay;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    push      = 1'b0;
    push_data = 8'h00;
    tx_busy   = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_sending", int'(sending), 0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("rst_ovf_cnt", int'(ovf_cnt), 0);
`endif
    exp_q.delete();
    occ        = 0;
    free_m     = 1'b1;
    seen_rise  = 1'b0;
    last_data  = 8'h00;
    ovf_m      = 0;
    rise_wait  = 0;
    busy_left  = 0;
    force_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while ((occ > 0 || !free_m || tx_busy) && k < max_cycles) begin
      step(1'b0, 8'h00);
      k++;
    end
    check("drain_timeout", int'(k < max_cycles), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bit p;
    reset      = 1'b1;
    push       = 1'b0;
    push_data  = 8'h00;
    tx_busy    = 1'b0;
    rand_mode  = 1'b0;
    rise_delay = 2;
    busy_len   = 160;
    n_starts   = 0;
    peak       = 0;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{push: 1'b1, data: 8'(i), exp_count: 5'(i + 1), exp_full: (i == 15), exp_ovf: 1'b0};
    end
    vecs[16] = '{push: 1'b1, data: 8'h10, exp_count: 5'd16, exp_full: 1'b1, exp_ovf: 1'b1};
    vecs[17] = '{push: 1'b0, data: 8'h00, exp_count: 5'd16, exp_full: 1'b1, exp_ovf: 1'b0};

    @(negedge clk);
    do_reset();

    // single byte, long busy window
    s0 = n_starts;
    step(1'b1, 8'h41);
    check("single_no_early_start", int'(tx_start), 0);
    check("single_not_empty", int'(empty), 0);
    step(1'b0, 8'h00);
    check("single_start", int'(tx_start), 1);
    check("single_data", int'(tx_data), 8'h41);
    drain(400);
    check("single_start_count", n_starts - s0, 1);
    check("single_count_zero", int'(count), 0);
    check("single_sending_low", int'(sending), 0);

    // burst of three
    busy_len = 4;
    peak     = 0;
    s0       = n_starts;
    step(1'b1, 8'h31);
    step(1'b1, 8'h32);
    step(1'b1, 8'h33);
    drain(200);
    check("burst_start_count", n_starts - s0, 3);
    check("burst_peak_ge2", int'(peak >= 2), 1);

    // wrap-around: 20 bytes through a 16-deep FIFO
    busy_len = 2;
    s0       = n_starts;
    for (int i = 0; i < 10; i++) step(1'b1, 8'h50 + 8'(i));
    drain(400);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h60 + 8'(i));
    drain(400);
    check("wrap_start_count", n_starts - s0, 20);

    // push while the transmitter is busy and the FIFO is empty
    busy_len = 10;
    step(1'b1, 8'h55);
    for (int k = 0; k < 20 && !(sending && tx_busy && seen_rise); k++) step(1'b0, 8'h00);
    check("pds_in_wait_idle", int'(sending && tx_busy), 1);
    step(1'b1, 8'hAA);
    check("pds_queued", int'(count), 1);
    check("pds_not_issued", int'(tx_start), 0);
    drain(200);

    // overflow table: transmitter held busy so nothing drains
    rise_delay = 1;
    busy_len   = 2;
    step(1'b1, 8'hEE);
    step(1'b0, 8'h00);
    force_busy = 1'b1;
    step(1'b0, 8'h00);
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].push, vecs[i].data);
      check("tbl_count", int'(count), int'(vecs[i].exp_count));
      check("tbl_full", int'(full), int'(vecs[i].exp_full));
      check("tbl_overflow", int'(overflow), int'(vecs[i].exp_ovf));
    end
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("tbl_ovf_cnt", int'(ovf_cnt), 1);
`endif
    force_busy = 1'b0;
    s0         = n_starts;
    drain(600);
    check("tbl_drained_16", n_starts - s0, 16);

    // reset while waiting for busy to rise
    rise_delay = 20;
    busy_len   = 5;
    for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i));
    check("mid_count5", int'(count), 5);
    check("mid_in_wait_busy", int'(sending && !tx_busy), 1);
    do_reset();
    s0 = n_starts;
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
    check("post_reset_no_start", n_starts - s0, 0);

    // random traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      p = ($urandom_range(0, 99) < 45);
      step(p, 8'($urandom_range(0, 255)));
    end
    drain(3000);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
